net_resolver_pipe: RTL and testbench
====================================

Name: net_resolver_pipe

Overview:
- Parametrised, registered resolver for multi-driven nets.
- Takes NDRV driver words, each a value plus a per-bit enable; disabled bits float.
- Resolves per bit under a run-time net-type mode: tri, wand, wor or tri1. Result is 4-state, in 2-bit encoding.
- Sits between the stimulus generator and the net checker; adds a single-stage valid/ready pipeline and a saturating conflict counter.

Parameters:
- NDRV, 4: number of drivers, 1..16.
- WIDTH, 8: bits per driver word, 1..64.
- CNT_W, 8: width of the conflict counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  input can be accepted.
- mode_i  in  2  net type, sampled on accept: 0 tri, 1 wand, 2 wor, 3 tri1.
- drv_val_i  in  NDRV*WIDTH  driver values; driver d occupies bits [d*WIDTH +: WIDTH].
- drv_en_i  in  NDRV*WIDTH  per-bit driver enables, same packing.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- res_o  out  2*WIDTH  resolved value; bit b in [2b+1:2b]; encoding 00=0, 01=1, 10=Z, 11=X.
- conflict_o  out  1  registered with res_o; any bit of the current result is X.
- conflict_cnt_o  out  CNT_W  count of accepted words that contained a conflict; saturating.
- clr_cnt_i  in  1  synchronous clear of conflict_cnt_o.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - out_valid=0, res_o all Z (2'b10 per bit), conflict_o=0, conflict_cnt_o=0.
  - Any in-flight word is dropped.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept = in_valid && in_ready.
  - On accept, the resolved word is registered; out_valid=1 the next cycle (latency 1).
  - A new accept in the same cycle as a downstream take gives back-to-back throughput of 1 word/cycle.
  - While out_valid && !out_ready: res_o, conflict_o and out_valid hold stable, and in_ready=0.
  - out_valid clears only on a downstream take with no new accept.
- Per-bit resolution: n0 = number of enabled drivers driving 0; n1 = number driving 1.
  - tri: n0=0 and n1=0 -> Z; n1=0 -> 0; n0=0 -> 1; else X (conflict).
  - tri1: as tri, except no driver -> 1.
  - wand: n0>0 -> 0; else n1>0 -> 1; else Z. Never conflicts.
  - wor: n1>0 -> 1; else n0>0 -> 0; else Z. Never conflicts.
  - Only presence matters (n>0); counts are not needed beyond that.
- Conflict counter:
  - Increments by 1 on each accept whose resolved word has any X bit.
  - Holds at 2^CNT_W-1 (saturates).
  - If clr_cnt_i and an incrementing accept occur in the same cycle, the counter becomes 1.
  - clr_cnt_i alone -> 0.
- mode_i changes between words are legal; each word uses the mode present on its own accept cycle.
- drv_val_i bits with their enable bit low are ignored completely.
- NDRV=1: tri/tri1 never conflict.

Decomposition:
- Package net_res_pkg:
  - typedef enum logic [1:0] {L0, L1, LZ, LX} lvl4_t;
  - typedef enum logic [1:0] {M_TRI, M_WAND, M_WOR, M_TRI1} net_mode_t;
  - function is_conflict(lvl4_t).
- Sub-module net_res_bit:
  - Combinational, one instance per bit (generate).
  - Inputs: NDRV enables, NDRV values, mode.
  - Outputs: lvl4_t.
- Top level holds the handshake register, the counter and the clear logic.

Test Plan:
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0 -> same cycle: out_valid=0, res_o=16'hAAAA (WIDTH=8), conflict_cnt_o=0.
- tri conflict, NDRV=4: driver0 en=8'hFF val=8'h0F; driver1 en=8'h01 val=8'h00; others disabled -> res_o bit0=X, bits1-3=1, bits4-7=0; conflict_o=1; cnt 0->1.
- wand vs wor on the same drivers (d0 val=8'hF0, d1 val=8'h3C, all enabled) -> wand res_o bits=8'h30, wor bits=8'hFC, conflict_o=0.
- tri1 all disabled -> res_o=16'h5555, conflict_o=0; tri all disabled -> 16'hAAAA.
- Backpressure: 3 words, out_ready low for 4 cycles -> in_ready=0, res_o stable; after release, words arrive in order at 1/cycle.
- Saturation, CNT_W=2: 5 conflicting accepts -> cnt 1,2,3,3,3; then clr_cnt_i with a conflicting accept -> 1.

Source files
------------

// File: rtl/net_res_pkg.sv
// Shared types for the multi-driven net resolver: 4-state levels in 2-bit
// encoding and the run-time net-type modes.
package net_res_pkg;

    typedef enum logic [1:0] {L0, L1, LZ, LX} lvl4_t;

    typedef enum logic [1:0] {M_TRI, M_WAND, M_WOR, M_TRI1} net_mode_t;

    function automatic logic is_conflict(lvl4_t lvl);
        return lvl == LX;
    endfunction

endpackage

// File: rtl/net_res_bit.sv
// Combinational resolution of one net bit from all drivers under the selected
// net type. Only the presence of a 0 or 1 driver matters, not the count.
module net_res_bit
    import net_res_pkg::*;
#(
    parameter int unsigned NDRV = 4
) (
    input  logic [NDRV-1:0] en,
    input  logic [NDRV-1:0] val,
    input  net_mode_t       mode,
    output lvl4_t           lvl
);

    logic any0;
    logic any1;

    assign any0 = |(en & ~val);
    assign any1 = |(en & val);

    always_comb begin
        lvl = LZ;
        unique case (mode)
            M_TRI: begin
                if (any0 && any1) lvl = LX;
                else if (any1)    lvl = L1;
                else if (any0)    lvl = L0;
                else              lvl = LZ;
            end
            M_TRI1: begin
                if (any0 && any1) lvl = LX;
                else if (any0)    lvl = L0;
                else              lvl = L1;
            end
            M_WAND: begin
                if (any0)         lvl = L0;
                else if (any1)    lvl = L1;
                else              lvl = LZ;
            end
            M_WOR: begin
                if (any1)         lvl = L1;
                else if (any0)    lvl = L0;
                else              lvl = LZ;
            end
            default: lvl = LZ;
        endcase
    end

endmodule

// File: rtl/net_resolver_pipe.sv
// Registered multi-driver net resolver: per-bit resolution, one-stage
// valid/ready register and a saturating count of conflicting words.
module net_resolver_pipe
    import net_res_pkg::*;
#(
    parameter int unsigned NDRV  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [1:0]              mode_i,
    input  logic [NDRV*WIDTH-1:0]   drv_val_i,
    input  logic [NDRV*WIDTH-1:0]   drv_en_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*WIDTH-1:0]      res_o,
    output logic                    conflict_o,
    output logic [CNT_W-1:0]        conflict_cnt_o,
    input  logic                    clr_cnt_i
);

    net_mode_t          mode;
    lvl4_t              lvl_w [WIDTH];
    logic [2*WIDTH-1:0] res_d, res_q;
    logic               conflict_d, conflict_q;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic               accept;
    logic               inc;

    assign mode = net_mode_t'(mode_i);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic [NDRV-1:0] en_b;
        logic [NDRV-1:0] val_b;
        for (genvar d = 0; d < NDRV; d++) begin : g_drv
            assign en_b[d]  = drv_en_i[d*WIDTH+b];
            assign val_b[d] = drv_val_i[d*WIDTH+b];
        end
        net_res_bit #(.NDRV(NDRV)) u_bit (
            .en  (en_b),
            .val (val_b),
            .mode(mode),
            .lvl (lvl_w[b])
        );
        assign res_d[2*b +: 2] = lvl_w[b];
    end

    always_comb begin
        conflict_d = 1'b0;
        for (int b = 0; b < WIDTH; b++) begin
            conflict_d = conflict_d | is_conflict(lvl_w[b]);
        end
    end

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign inc      = accept && conflict_d;

    // A clear coinciding with a counted word leaves exactly that word counted.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt_i) begin
            cnt_d = inc ? CNT_W'(1) : '0;
        end else if (inc && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            res_q      <= {WIDTH{LZ}};
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (accept) begin
                valid_q    <= 1'b1;
                res_q      <= res_d;
                conflict_q <= conflict_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = valid_q;
    assign res_o          = res_q;
    assign conflict_o     = conflict_q;
    assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_net_resolver_pipe.sv
// Directed bench for net_resolver_pipe: default instance plus a CNT_W=2
// instance sharing the same stimulus to exercise counter saturation.
module tb_net_resolver_pipe;

    localparam int NDRV  = 4;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic [1:0]            mode_i;
    logic [NDRV*WIDTH-1:0] drv_val_i;
    logic [NDRV*WIDTH-1:0] drv_en_i;
    logic                  out_ready;
    logic                  clr_cnt_i;

    logic                  in_ready, in_ready2;
    logic                  out_valid, out_valid2;
    logic [2*WIDTH-1:0]    res_o, res2;
    logic                  conflict_o, conflict2;
    logic [7:0]            cnt;
    logic [1:0]            cnt2;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    net_resolver_pipe #(.NDRV(NDRV), .WIDTH(WIDTH), .CNT_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mode_i        (mode_i),
        .drv_val_i     (drv_val_i),
        .drv_en_i      (drv_en_i),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .res_o         (res_o),
        .conflict_o    (conflict_o),
        .conflict_cnt_o(cnt),
        .clr_cnt_i     (clr_cnt_i)
    );

    net_resolver_pipe #(.NDRV(NDRV), .WIDTH(WIDTH), .CNT_W(2)) dut_sat (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready2),
        .mode_i        (mode_i),
        .drv_val_i     (drv_val_i),
        .drv_en_i      (drv_en_i),
        .out_valid     (out_valid2),
        .out_ready     (out_ready),
        .res_o         (res2),
        .conflict_o    (conflict2),
        .conflict_cnt_o(cnt2),
        .clr_cnt_i     (clr_cnt_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_drv();
        drv_en_i  = '0;
        drv_val_i = '0;
    endtask

    task automatic set_drv(input int d, input logic [7:0] en, input logic [7:0] val);
        drv_en_i[d*WIDTH +: WIDTH]  = en;
        drv_val_i[d*WIDTH +: WIDTH] = val;
    endtask

    // tri word with a conflict on bit 0 only
    task automatic load_conflict();
        clear_drv();
        mode_i = 2'd0;
        set_drv(0, 8'hFF, 8'h0F);
        set_drv(1, 8'h01, 8'h00);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode_i    = 2'd0;
        out_ready = 1'b1;
        clr_cnt_i = 1'b0;
        clear_drv();
        #12;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_res", 64'(res_o), 64'hAAAA);
        check("rst_conflict", 64'(conflict_o), 64'd0);
        check("rst_cnt", 64'(cnt), 64'd0);
        rst_n = 1'b1;
        step();

        // tri conflict
        load_conflict();
        in_valid = 1'b1;
        step();
        check("tri_valid", 64'(out_valid), 64'd1);
        check("tri_res", 64'(res_o), 64'h0057);
        check("tri_conflict", 64'(conflict_o), 64'd1);
        check("tri_cnt", 64'(cnt), 64'd1);

        // wand then wor, back to back
        clear_drv();
        set_drv(0, 8'hFF, 8'hF0);
        set_drv(1, 8'hFF, 8'h3C);
        mode_i = 2'd1;
        step();
        check("wand_res", 64'(res_o), 64'h0500);
        check("wand_conflict", 64'(conflict_o), 64'd0);
        mode_i = 2'd2;
        step();
        check("wor_res", 64'(res_o), 64'h5550);
        check("wor_conflict", 64'(conflict_o), 64'd0);
        check("wor_cnt", 64'(cnt), 64'd1);

        // all drivers off
        clear_drv();
        mode_i = 2'd3;
        step();
        check("tri1_off_res", 64'(res_o), 64'h5555);
        check("tri1_off_conflict", 64'(conflict_o), 64'd0);
        mode_i = 2'd0;
        step();
        check("tri_off_res", 64'(res_o), 64'hAAAA);
        in_valid = 1'b0;
        step();
        check("drain_valid", 64'(out_valid), 64'd0);

        // backpressure: three words held off for four cycles
        out_ready = 1'b0;
        in_valid  = 1'b1;
        set_drv(0, 8'hFF, 8'h11);
        step();
        check("bp_a_res", 64'(res_o), 64'h0101);
        set_drv(0, 8'hFF, 8'h22);
        for (int i = 0; i < 4; i++) begin
            check("bp_in_ready", 64'(in_ready), 64'd0);
            step();
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_res", 64'(res_o), 64'h0101);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        check("bp_b_res", 64'(res_o), 64'h0404);
        set_drv(0, 8'hFF, 8'h44);
        step();
        check("bp_c_res", 64'(res_o), 64'h1010);
        in_valid = 1'b0;
        step();
        check("bp_drain", 64'(out_valid), 64'd0);
        check("bp_cnt", 64'(cnt), 64'd1);

        // clear alone, then saturation on the 2-bit counter
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        check("clr_cnt", 64'(cnt), 64'd0);
        check("clr_cnt2", 64'(cnt2), 64'd0);
        load_conflict();
        in_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            check("sat_cnt2", 64'(cnt2), 64'((i > 3) ? 3 : i));
            check("sat_cnt", 64'(cnt), 64'(i));
        end
        clr_cnt_i = 1'b1;
        step();
        clr_cnt_i = 1'b0;
        check("clr_inc_cnt2", 64'(cnt2), 64'd1);
        check("clr_inc_cnt", 64'(cnt), 64'd1);

        // reset while a word is stalled
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_res", 64'(res_o), 64'hAAAA);
        check("mid_rst_cnt", 64'(cnt), 64'd0);
        step();
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
